// File: rtl/io_ccff_loader.sv
// Configuration-chain loader for a column of I/O tiles: accepts bitstream words over valid/ready
// and shifts them LSB-first into the ccff chain while holding the pads isolated.
module io_ccff_loader #(
  parameter int unsigned CHAIN_LEN = 4,
  parameter int unsigned WORD_W    = 8,
  localparam int unsigned CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              isol_n,
  output logic              busy,
  output logic              done,
  output logic              tail_parity
);

  localparam int unsigned WB_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISOLATE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [WB_W-1:0]   word_bits_q, word_bits_d;
  logic              parity_q, parity_d;
  logic              isol_n_q, isol_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state and datapath update; abort overrides whatever the state decided.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bits_left_d = bits_left_q;
    word_bits_d = word_bits_q;
    parity_d    = parity_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_ISOLATE;
          bits_left_d = CNT_W'(CHAIN_LEN);
          parity_d    = 1'b0;
        end
      end
      S_ISOLATE: state_d = S_LOAD;
      S_LOAD: begin
        if (cfg_valid) begin
          sreg_d  = cfg_data;
          state_d = S_SHIFT;
          if (32'(bits_left_q) > WORD_W) word_bits_d = WB_W'(WORD_W);
          else                           word_bits_d = WB_W'(bits_left_q);
        end
      end
      S_SHIFT: begin
        sreg_d      = sreg_q >> 1;
        bits_left_d = bits_left_q - CNT_W'(1);
        word_bits_d = word_bits_q - WB_W'(1);
        parity_d    = parity_q ^ ccff_tail;
        if (bits_left_q == CNT_W'(1))      state_d = S_DONE;
        else if (word_bits_q == WB_W'(1))  state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      parity_d = parity_q;
    end

    isol_n_d = (state_d == S_DONE);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d == S_ISOLATE) || (state_d == S_LOAD) || (state_d == S_SHIFT);
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      bits_left_q <= '0;
      word_bits_q <= '0;
      parity_q    <= 1'b0;
      isol_n_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bits_left_q <= bits_left_d;
      word_bits_q <= word_bits_d;
      parity_q    <= parity_d;
      isol_n_q    <= isol_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Handshake and chain enable decode straight from the state register.
  assign cfg_ready   = (state_q == S_LOAD);
  assign shift_en    = (state_q == S_SHIFT);
  assign ccff_head   = shift_en & sreg_q[0];
  assign isol_n      = isol_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tail_parity = parity_q;

endmodule

// File: tb/tb_io_ccff_loader.sv
// Directed bench for io_ccff_loader: a 10-bit/4-bit-word instance against a chain model,
// plus a 4-bit/8-bit-word instance for the partial-word case.
module tb_io_ccff_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, a_abort, a_valid, a_ready, a_head, a_shift, a_tail;
  logic       a_isol_n, a_busy, a_done, a_par;
  logic [3:0] a_data;

  logic       b_start, b_abort, b_valid, b_ready, b_head, b_shift, b_tail;
  logic       b_isol_n, b_busy, b_done, b_par;
  logic [7:0] b_data;

  io_ccff_loader #(.CHAIN_LEN(10), .WORD_W(4)) u_a (
    .prog_clk(clk), .prog_reset(rst), .start(a_start), .abort(a_abort),
    .cfg_data(a_data), .cfg_valid(a_valid), .cfg_ready(a_ready),
    .ccff_head(a_head), .shift_en(a_shift), .ccff_tail(a_tail),
    .isol_n(a_isol_n), .busy(a_busy), .done(a_done), .tail_parity(a_par)
  );

  io_ccff_loader #(.CHAIN_LEN(4), .WORD_W(8)) u_b (
    .prog_clk(clk), .prog_reset(rst), .start(b_start), .abort(b_abort),
    .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .ccff_head(b_head), .shift_en(b_shift), .ccff_tail(b_tail),
    .isol_n(b_isol_n), .busy(b_busy), .done(b_done), .tail_parity(b_par)
  );

  // Chain model: index 0 sits at the head, index 9 drives the tail.
  logic [9:0] chain_m;
  logic       preload_req;
  logic [9:0] preload_val;
  assign a_tail = chain_m[9];
  always @(posedge clk) begin
    if (preload_req)  chain_m <= preload_val;
    else if (a_shift) chain_m <= {chain_m[8:0], a_head};
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] v);
    @(negedge clk);
    preload_req = 1'b1;
    preload_val = v;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  // Runs one load on instance A; optionally stops (or aborts) once stop_at shift pulses are seen.
  task automatic run_a(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                       input int gap_word, input int gap_len, input bit hold_start,
                       input int stop_at, input bit do_abort,
                       output int lat, output int hs, output int nsh,
                       output logic [9:0] heads, output int isol_bad);
    logic [3:0] wa [3];
    int cyc, widx, gapc;
    wa[0] = w0; wa[1] = w1; wa[2] = w2;
    lat = -1; hs = 0; nsh = 0; heads = '0; isol_bad = 0;
    cyc = 0; widx = 0; gapc = 0;
    a_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start = hold_start;
    chk("isolate_isol_n", 32'(a_isol_n), 32'd0);
    chk("isolate_busy",   32'(a_busy),   32'd1);
    chk("isolate_done",   32'(a_done),   32'd0);
    while (cyc < 100) begin
      if (a_done) begin
        lat = cyc;
        break;
      end
      if (a_isol_n) isol_bad++;
      a_valid = 1'b0;
      if (a_shift) begin
        if (nsh < 10) heads[nsh] = a_head;
        nsh++;
        if (stop_at != 0 && nsh == stop_at) begin
          if (do_abort) a_abort = 1'b1;
          else break;
        end
      end
      if (a_ready && widx < 3) begin
        if (widx == gap_word && gapc < gap_len) gapc++;
        else begin
          a_valid = 1'b1;
          a_data  = wa[widx];
          widx++;
          hs++;
        end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (a_abort) begin
        a_abort = 1'b0;
        break;
      end
    end
    a_start = 1'b0;
    a_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] w0, w1, w2;
    int         gap_word;
    int         gap_len;
    bit         hold_start;
    logic [9:0] pre;
    logic [9:0] exp_heads;
    int         exp_lat;
    logic       exp_par;
  } row_t;

  initial begin
    row_t rows [4];
    int lat, hs, nsh, isol_bad, cyc, n, extra;
    logic [9:0] heads, exp_chain;
    logic [3:0] bheads;

    rows[0] = '{4'h5, 4'hA, 4'h3, -1, 0, 1'b0, 10'b0000000000, 10'b1110100101, 14, 1'b0};
    rows[1] = '{4'h5, 4'hA, 4'h3,  1, 5, 1'b0, 10'b1101000001, 10'b1110100101, 19, 1'b0};
    rows[2] = '{4'h5, 4'hA, 4'h3, -1, 0, 1'b0, 10'b1101000101, 10'b1110100101, 14, 1'b1};
    rows[3] = '{4'hC, 4'h9, 4'hE, -1, 0, 1'b1, 10'b1111111111, 10'b1010011100, 14, 1'b0};

    rst = 1'b1;
    a_start = 0; a_abort = 0; a_valid = 0; a_data = '0;
    b_start = 0; b_abort = 0; b_valid = 0; b_data = '0; b_tail = 1'b0;
    preload_req = 1'b0; preload_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_isol_n",    32'(a_isol_n), 32'd0);
    chk("rst_cfg_ready", 32'(a_ready),  32'd0);
    chk("rst_shift_en",  32'(a_shift),  32'd0);
    chk("rst_head",      32'(a_head),   32'd0);
    chk("rst_busy",      32'(a_busy),   32'd0);
    chk("rst_done",      32'(a_done),   32'd0);
    chk("rst_parity",    32'(a_par),    32'd0);
    rst = 1'b0;
    preload(10'b0);

    // Table-driven full loads; rows after the first also exercise restart from DONE.
    for (int r = 0; r < 4; r++) begin
      preload(rows[r].pre);
      run_a(rows[r].w0, rows[r].w1, rows[r].w2, rows[r].gap_word, rows[r].gap_len,
            rows[r].hold_start, 0, 1'b0, lat, hs, nsh, heads, isol_bad);
      for (int k = 0; k < 10; k++) exp_chain[9-k] = rows[r].exp_heads[k];
      chk($sformatf("row%0d_latency", r),    32'(lat),      32'(rows[r].exp_lat));
      chk($sformatf("row%0d_handshakes", r), 32'(hs),       32'd3);
      chk($sformatf("row%0d_shifts", r),     32'(nsh),      32'd10);
      chk($sformatf("row%0d_heads", r),      32'(heads),    32'(rows[r].exp_heads));
      chk($sformatf("row%0d_parity", r),     32'(a_par),    32'(rows[r].exp_par));
      chk($sformatf("row%0d_isol_early", r), 32'(isol_bad), 32'd0);
      chk($sformatf("row%0d_isol_n", r),     32'(a_isol_n), 32'd1);
      chk($sformatf("row%0d_busy", r),       32'(a_busy),   32'd0);
      chk($sformatf("row%0d_chain", r),      32'(chain_m),  32'(exp_chain));
    end

    // Abort after the 6th shift pulse.
    preload(10'b0);
    run_a(4'h5, 4'hA, 4'h3, -1, 0, 1'b0, 6, 1'b1, lat, hs, nsh, heads, isol_bad);
    chk("abort_shifts", 32'(nsh),      32'd6);
    chk("abort_busy",   32'(a_busy),   32'd0);
    chk("abort_done",   32'(a_done),   32'd0);
    chk("abort_isol_n", 32'(a_isol_n), 32'd0);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_shift || a_ready) extra++;
      @(negedge clk);
    end
    chk("abort_quiet",  32'(extra),       32'd0);
    chk("abort_chain",  32'(chain_m[5:0]), 32'b101001);
    run_a(4'h5, 4'hA, 4'h3, -1, 0, 1'b0, 0, 1'b0, lat, hs, nsh, heads, isol_bad);
    chk("reload_shifts", 32'(nsh),   32'd10);
    chk("reload_heads",  32'(heads), 32'b1110100101);
    chk("reload_done",   32'(a_done), 32'd1);

    // Asynchronous reset in the middle of SHIFT.
    preload(10'h3FF);
    run_a(4'h5, 4'hA, 4'h3, -1, 0, 1'b0, 2, 1'b0, lat, hs, nsh, heads, isol_bad);
    chk("mid_shift_en",  32'(a_shift), 32'd1);
    chk("mid_parity",    32'(a_par),   32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_shift_en", 32'(a_shift),  32'd0);
    chk("arst_busy",     32'(a_busy),   32'd0);
    chk("arst_parity",   32'(a_par),    32'd0);
    chk("arst_isol_n",   32'(a_isol_n), 32'd0);
    chk("arst_ready",    32'(a_ready),  32'd0);
    chk("arst_head",     32'(a_head),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_idle", 32'({a_busy, a_done, a_shift}), 32'd0);

    // Instance B: single 8-bit word into a 4-bit chain, upper nibble dropped.
    b_valid = 1'b1;
    b_data  = 8'hF6;
    b_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_start = 1'b0;
    cyc = 0; hs = 0; n = 0; bheads = '0;
    while (cyc < 50 && !b_done) begin
      if (b_shift) begin
        if (n < 4) bheads[n] = b_head;
        n++;
      end
      if (b_ready) hs++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("b_latency",    32'(cyc),      32'd6);
    chk("b_handshakes", 32'(hs),       32'd1);
    chk("b_shifts",     32'(n),        32'd4);
    chk("b_heads",      32'(bheads),   32'b0110);
    chk("b_isol_n",     32'(b_isol_n), 32'd1);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      if (b_ready || b_shift) extra++;
      @(negedge clk);
    end
    chk("b_no_more_words", 32'(extra), 32'd0);
    b_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
